// File: rtl/spad_seq_ctrl_pkg.sv
// Shared types and constants for the scratchpad sequencing controller.
// Holds the FSM state encoding, drain length and kernel-mode encodings.
package spad_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRELOAD,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam int   DRAIN_CYCLES = 3;
    localparam logic KN_MODE_5    = 1'b0;
    localparam logic KN_MODE_3    = 1'b1;

    // A 3x3 kernel only occupies the bottom three lines of the scratchpad.
    function automatic logic [3:0] first_line(input logic kn_mode);
        return (kn_mode == KN_MODE_3) ? 4'd2 : 4'd0;
    endfunction

endpackage

// File: rtl/spad_beat_counter.sv
// Non-wrapping up-counter with a terminal flag; once the limit is reached it
// parks in a done state until reloaded.
import spad_seq_ctrl_pkg::*;

module spad_beat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic             last_o,
    output logic             done_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    // last_o flags the cycle whose enabled event completes the count.
    assign last_o = !done_q && (cnt_q == limit_i - WIDTH'(1));
    assign done_o = done_q;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = done_q;
        if (load_i) begin
            cnt_d  = '0;
            done_d = 1'b0;
        end else if (en_i && !done_q) begin
            if (last_o) done_d = 1'b1;
            else        cnt_d  = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

endmodule

// File: rtl/spad_seq_ctrl.sv
// Sequences one convolution tile: preload kernel lines into the scratchpad,
// then stream reads row by row while refilling the bottom line.
import spad_seq_ctrl_pkg::*;

module spad_seq_ctrl #(
    parameter int KERNEL_SIZE    = 5,
    parameter int DATA_BUS_WIDTH = 128,
    parameter int FEATURE_WIDTH  = 16,
    parameter int BEAT_W         = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      cfg_kn_mode,
    input  logic [BEAT_W-1:0]         cfg_row_beats,
    input  logic [BEAT_W-1:0]         cfg_out_rows,
    input  logic                      fetch_valid,
    input  logic [DATA_BUS_WIDTH-1:0] fetch_data,
    output logic                      fetch_ready,
    output logic                      spad_wr_en,
    output logic [3:0]                spad_wr_mem_line,
    output logic [DATA_BUS_WIDTH-1:0] spad_i_data,
    output logic                      spad_rd_en,
    output logic                      spad_kn_size_mode,
    input  logic                      spad_group_empty,
    input  logic                      spad_group_full,
    output logic                      busy,
    output logic                      done
);

    localparam int         FPB       = DATA_BUS_WIDTH / FEATURE_WIDTH;
    localparam int         RD_W      = BEAT_W + $clog2(FPB);
    localparam logic [3:0] LAST_LINE = 4'(KERNEL_SIZE - 1);

    state_e            state_q, state_d;
    logic              kn_mode_q, kn_mode_d;
    logic [BEAT_W-1:0] row_beats_q, row_beats_d;
    logic [BEAT_W-1:0] out_rows_q, out_rows_d;
    logic [BEAT_W-1:0] row_q, row_d;
    logic [3:0]        line_q, line_d;
    logic [1:0]        drain_q, drain_d;

    logic              accept, refill;
    logic [BEAT_W:0]   row_nxt;
    logic [RD_W-1:0]   rd_limit;
    logic              wr_load, wr_en, wr_last, wr_done;
    logic              rd_load, rd_last, rd_done;

    assign row_nxt  = {1'b0, row_q} + {{BEAT_W{1'b0}}, 1'b1};
    assign refill   = row_nxt < {1'b0, out_rows_q};
    assign rd_limit = RD_W'(row_beats_q) * RD_W'(FPB);

    assign busy              = (state_q != ST_IDLE);
    assign spad_kn_size_mode = kn_mode_q;
    assign spad_wr_mem_line  = line_q;
    assign spad_i_data       = fetch_data;
    assign accept            = fetch_valid && fetch_ready;
    assign spad_wr_en        = accept;

    always_comb begin
        fetch_ready = 1'b0;
        spad_rd_en  = 1'b0;
        case (state_q)
            ST_PRELOAD: fetch_ready = !spad_group_full;
            ST_READ: begin
                fetch_ready = refill && !wr_done && !spad_group_full;
                spad_rd_en  = !spad_group_empty && !rd_done;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        kn_mode_d   = kn_mode_q;
        row_beats_d = row_beats_q;
        out_rows_d  = out_rows_q;
        row_d       = row_q;
        line_d      = line_q;
        drain_d     = drain_q;
        done        = 1'b0;
        wr_load     = 1'b0;
        wr_en       = 1'b0;
        rd_load     = 1'b1;
        case (state_q)
            ST_IDLE: begin
                wr_load = 1'b1;
                if (start) begin
                    kn_mode_d   = cfg_kn_mode;
                    row_beats_d = cfg_row_beats;
                    out_rows_d  = cfg_out_rows;
                    row_d       = '0;
                    line_d      = first_line(cfg_kn_mode);
                    state_d     = ST_PRELOAD;
                end
            end
            ST_PRELOAD: begin
                wr_en = accept;
                if (accept && wr_last) begin
                    wr_load = 1'b1;
                    if (line_q == LAST_LINE) state_d = ST_READ;
                    else                     line_d  = line_q + 4'd1;
                end
            end
            ST_READ: begin
                rd_load = 1'b0;
                wr_en   = accept;
                // Both streams must finish; either may complete last.
                if ((rd_done || (spad_rd_en && rd_last)) &&
                    (!refill || wr_done || (accept && wr_last))) begin
                    drain_d = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                wr_load = 1'b1;
                drain_d = drain_q + 2'd1;
                if (drain_q == 2'(DRAIN_CYCLES - 1)) begin
                    drain_d = '0;
                    row_d   = row_nxt[BEAT_W-1:0];
                    state_d = refill ? ST_READ : ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            kn_mode_q   <= KN_MODE_5;
            row_beats_q <= '0;
            out_rows_q  <= '0;
            row_q       <= '0;
            line_q      <= '0;
            drain_q     <= '0;
        end else begin
            state_q     <= state_d;
            kn_mode_q   <= kn_mode_d;
            row_beats_q <= row_beats_d;
            out_rows_q  <= out_rows_d;
            row_q       <= row_d;
            line_q      <= line_d;
            drain_q     <= drain_d;
        end
    end

    spad_beat_counter #(.WIDTH(BEAT_W)) u_wr_cnt (
        .clk     (clk),
        .rst     (rst),
        .load_i  (wr_load),
        .en_i    (wr_en),
        .limit_i (row_beats_q),
        .last_o  (wr_last),
        .done_o  (wr_done)
    );

    spad_beat_counter #(.WIDTH(RD_W)) u_rd_cnt (
        .clk     (clk),
        .rst     (rst),
        .load_i  (rd_load),
        .en_i    (spad_rd_en),
        .limit_i (rd_limit),
        .last_o  (rd_last),
        .done_o  (rd_done)
    );

endmodule

// File: tb/tb_spad_seq_ctrl.sv
// Directed bench for spad_seq_ctrl: each task runs one tile scenario and
// checks write lines, read counts and done timing against hand-derived values.
module tb_spad_seq_ctrl;

    localparam int KS = 5, DBW = 128, FW = 16, BW = 8;

    logic           clk = 1'b0;
    logic           rst, start, cfg_kn_mode;
    logic [BW-1:0]  cfg_row_beats, cfg_out_rows;
    logic           fetch_valid, fetch_ready, spad_wr_en;
    logic [DBW-1:0] fetch_data, spad_i_data;
    logic [3:0]     spad_wr_mem_line;
    logic           spad_rd_en, spad_kn_size_mode, spad_group_empty, spad_group_full;
    logic           busy, done;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, t0 = 0;
    logic [3:0]     wr_lines[$];
    int             wr_cyc[$];
    logic [DBW-1:0] wr_data[$];
    int rd_cnt, rd_bad, wr_bad, kn_bad, done_cnt, done_cyc;
    logic exp_kn;

    spad_seq_ctrl #(.KERNEL_SIZE(KS), .DATA_BUS_WIDTH(DBW), .FEATURE_WIDTH(FW), .BEAT_W(BW)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_kn_mode(cfg_kn_mode),
        .cfg_row_beats(cfg_row_beats), .cfg_out_rows(cfg_out_rows),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_ready(fetch_ready),
        .spad_wr_en(spad_wr_en), .spad_wr_mem_line(spad_wr_mem_line), .spad_i_data(spad_i_data),
        .spad_rd_en(spad_rd_en), .spad_kn_size_mode(spad_kn_size_mode),
        .spad_group_empty(spad_group_empty), .spad_group_full(spad_group_full),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [DBW-1:0] pat(input int c);
        return {4{32'hC0DE_0000 + 32'(c)}};
    endfunction

    task automatic clr_mon();
        wr_lines.delete(); wr_cyc.delete(); wr_data.delete();
        rd_cnt = 0; rd_bad = 0; wr_bad = 0; kn_bad = 0; done_cnt = 0; done_cyc = -1;
    endtask

    // One clock: record what the DUT shows mid-cycle, end at posedge+1.
    task automatic tick();
        fetch_data = pat(cyc);
        @(negedge clk);
        if (spad_wr_en) begin
            wr_lines.push_back(spad_wr_mem_line); wr_cyc.push_back(cyc); wr_data.push_back(spad_i_data);
        end
        if (spad_wr_en && !fetch_valid) wr_bad++;
        if (spad_rd_en) rd_cnt++;
        if (spad_rd_en && spad_group_empty) rd_bad++;
        if (busy && spad_kn_size_mode !== exp_kn) kn_bad++;
        if (done) begin done_cnt++; done_cyc = cyc; end
        cyc++;
        @(posedge clk); #1;
    endtask

    task automatic launch(input logic kn, input int rb, input int rows);
        clr_mon();
        exp_kn = kn; cfg_kn_mode = kn; cfg_row_beats = BW'(rb); cfg_out_rows = BW'(rows);
        start = 1'b1; t0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; cfg_kn_mode = 1'b0; cfg_row_beats = '0; cfg_out_rows = '0;
        fetch_valid = 1'b1; fetch_data = '0; spad_group_empty = 1'b0; spad_group_full = 1'b0;
        #12;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (fetch_ready !== 1'b0) $display("FAIL reset_fetch_ready: got %b want 0", fetch_ready); else n_pass++;
        n_chk++; if (spad_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", spad_wr_en); else n_pass++;
        n_chk++; if (spad_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", spad_rd_en); else n_pass++;
        n_chk++; if ({done, spad_kn_size_mode, spad_wr_mem_line} !== 6'b0)
            $display("FAIL reset_misc: got done/kn/line %b/%b/%0d want 0/0/0", done, spad_kn_size_mode, spad_wr_mem_line); else n_pass++;
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_idle_after_release: busy got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_5x5_single();
        fetch_valid = 1'b1;
        launch(1'b0, 2, 1);
        for (int n = 0; n < 100 && done_cnt == 0; n++) tick();
        n_chk++; if (wr_lines.size() != 10) $display("FAIL 5x5_nwrites: got %0d want 10", wr_lines.size()); else n_pass++;
        for (int i = 0; i < 10 && i < wr_lines.size(); i++) begin
            n_chk++; if (wr_lines[i] !== 4'(i / 2) || wr_cyc[i] != t0 + 1 + i)
                $display("FAIL 5x5_write%0d: got line %0d rel %0d want line %0d rel %0d", i, wr_lines[i], wr_cyc[i] - t0, i / 2, i + 1);
            else n_pass++;
        end
        if (wr_data.size() > 0) begin
            n_chk++; if (wr_data[0] !== pat(t0 + 1)) $display("FAIL 5x5_wdata: got %h want %h", wr_data[0], pat(t0 + 1)); else n_pass++;
        end
        n_chk++; if (rd_cnt != 16) $display("FAIL 5x5_reads: got %0d want 16", rd_cnt); else n_pass++;
        n_chk++; if (done_cyc != t0 + 30 || done_cnt != 1)
            $display("FAIL 5x5_done: got rel %0d cnt %0d want rel 30 cnt 1", done_cyc - t0, done_cnt); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL 5x5_idle: busy got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_3x3_refill();
        logic [3:0] el[4] = '{4'd2, 4'd3, 4'd4, 4'd4};
        fetch_valid = 1'b1;
        launch(1'b1, 1, 2);
        for (int n = 0; n < 100 && done_cnt == 0; n++) tick();
        n_chk++; if (wr_lines.size() != 4) $display("FAIL 3x3_nwrites: got %0d want 4", wr_lines.size()); else n_pass++;
        for (int i = 0; i < 4 && i < wr_lines.size(); i++) begin
            n_chk++; if (wr_lines[i] !== el[i] || wr_cyc[i] != t0 + 1 + i)
                $display("FAIL 3x3_write%0d: got line %0d rel %0d want line %0d rel %0d", i, wr_lines[i], wr_cyc[i] - t0, el[i], i + 1);
            else n_pass++;
        end
        n_chk++; if (rd_cnt != 16) $display("FAIL 3x3_reads: got %0d want 16", rd_cnt); else n_pass++;
        n_chk++; if (kn_bad != 0) $display("FAIL 3x3_kn_mode: %0d busy cycles with mode != 1, want 0", kn_bad); else n_pass++;
        n_chk++; if (done_cyc != t0 + 26 || done_cnt != 1)
            $display("FAIL 3x3_done: got rel %0d cnt %0d want rel 26 cnt 1", done_cyc - t0, done_cnt); else n_pass++;
    endtask

    task automatic test_fetch_toggle();
        int rel;
        fetch_valid = 1'b0;
        launch(1'b0, 2, 1);
        for (int n = 0; n < 100 && done_cnt == 0; n++) begin
            rel = cyc - t0;
            fetch_valid = rel[0];
            tick();
        end
        fetch_valid = 1'b0;
        n_chk++; if (wr_lines.size() != 10) $display("FAIL toggle_nwrites: got %0d want 10", wr_lines.size()); else n_pass++;
        n_chk++; if (wr_bad != 0) $display("FAIL toggle_wr_without_valid: got %0d want 0", wr_bad); else n_pass++;
        for (int i = 0; i < 10 && i < wr_lines.size(); i++) begin
            n_chk++; if (wr_lines[i] !== 4'(i / 2) || wr_cyc[i] != t0 + 1 + 2 * i)
                $display("FAIL toggle_write%0d: got line %0d rel %0d want line %0d rel %0d", i, wr_lines[i], wr_cyc[i] - t0, i / 2, 1 + 2 * i);
            else n_pass++;
        end
        n_chk++; if (done_cyc != t0 + 39) $display("FAIL toggle_done: got rel %0d want 39", done_cyc - t0); else n_pass++;
    endtask

    task automatic test_empty_stall();
        int rel;
        fetch_valid = 1'b1;
        launch(1'b0, 2, 1);
        for (int n = 0; n < 100 && done_cnt == 0; n++) begin
            rel = cyc - t0;
            spad_group_empty = (rel >= 15 && rel <= 18);
            tick();
        end
        spad_group_empty = 1'b0;
        n_chk++; if (rd_bad != 0) $display("FAIL stall_rd_while_empty: got %0d want 0", rd_bad); else n_pass++;
        n_chk++; if (rd_cnt != 16) $display("FAIL stall_reads: got %0d want 16", rd_cnt); else n_pass++;
        n_chk++; if (done_cyc != t0 + 34) $display("FAIL stall_done: got rel %0d want 34", done_cyc - t0); else n_pass++;
    endtask

    task automatic test_rst_mid();
        fetch_valid = 1'b1;
        launch(1'b1, 1, 2);
        while (cyc - t0 < 8) tick();
        n_chk++; if ({busy, spad_rd_en, spad_kn_size_mode, spad_wr_mem_line} !== 7'b111_0100)
            $display("FAIL rstmid_pre: got busy/rd/kn/line %b/%b/%b/%0d want 1/1/1/4", busy, spad_rd_en, spad_kn_size_mode, spad_wr_mem_line);
        else n_pass++;
        #3 rst = 1'b1;
        #1;
        n_chk++; if ({busy, spad_rd_en, fetch_ready, spad_wr_en, done} !== 5'b0)
            $display("FAIL rstmid_ctrl: got busy/rd/rdy/wr/done %b/%b/%b/%b/%b want all 0", busy, spad_rd_en, fetch_ready, spad_wr_en, done);
        else n_pass++;
        n_chk++; if ({spad_kn_size_mode, spad_wr_mem_line} !== 5'b0)
            $display("FAIL rstmid_state: got kn/line %b/%0d want 0/0", spad_kn_size_mode, spad_wr_mem_line); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (done !== 1'b0 || done_cnt != 0) $display("FAIL rstmid_no_done: got done %b cnt %0d want 0", done, done_cnt); else n_pass++;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        launch(1'b0, 2, 1);
        for (int n = 0; n < 100 && done_cnt == 0; n++) tick();
        n_chk++; if (wr_lines.size() != 10 || rd_cnt != 16 || done_cyc != t0 + 30)
            $display("FAIL rstmid_clean_tile: got writes %0d reads %0d done rel %0d want 10/16/30", wr_lines.size(), rd_cnt, done_cyc - t0);
        else n_pass++;
    endtask

    task automatic test_start_busy();
        int rel;
        logic [3:0] el[3] = '{4'd2, 4'd3, 4'd4};
        fetch_valid = 1'b1;
        launch(1'b1, 1, 1);
        for (int n = 0; n < 100 && done_cnt == 0; n++) begin
            rel = cyc - t0;
            spad_group_full = (rel == 1);
            start = (rel == 3);
            if (rel == 3) begin cfg_kn_mode = 1'b0; cfg_row_beats = 8'd3; cfg_out_rows = 8'd5; end
            if (rel == 1) begin
                #1;
                n_chk++; if (fetch_ready !== 1'b0 || spad_wr_en !== 1'b0)
                    $display("FAIL busy_full_backpressure: got rdy/wr %b/%b want 0/0", fetch_ready, spad_wr_en); else n_pass++;
            end
            tick();
        end
        start = 1'b0; spad_group_full = 1'b0;
        n_chk++; if (wr_lines.size() != 3) $display("FAIL busy_nwrites: got %0d want 3", wr_lines.size()); else n_pass++;
        for (int i = 0; i < 3 && i < wr_lines.size(); i++) begin
            n_chk++; if (wr_lines[i] !== el[i] || wr_cyc[i] != t0 + 2 + i)
                $display("FAIL busy_write%0d: got line %0d rel %0d want line %0d rel %0d", i, wr_lines[i], wr_cyc[i] - t0, el[i], i + 2);
            else n_pass++;
        end
        n_chk++; if (rd_cnt != 8) $display("FAIL busy_reads: got %0d want 8", rd_cnt); else n_pass++;
        n_chk++; if (kn_bad != 0) $display("FAIL busy_kn_mode: %0d cycles changed, want 0", kn_bad); else n_pass++;
        n_chk++; if (done_cyc != t0 + 16 || done_cnt != 1)
            $display("FAIL busy_done: got rel %0d cnt %0d want rel 16 cnt 1", done_cyc - t0, done_cnt); else n_pass++;
    endtask

    initial begin
        exp_kn = 1'b0;
        clr_mon();
        test_reset();
        test_5x5_single();
        test_3x3_refill();
        test_fetch_toggle();
        test_empty_stall();
        test_rst_mid();
        test_start_busy();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spad_seq_ctrl.md
SPAD_SEQ_CTRL -- requirements
Module: spad_seq_ctrl

Interface
REQ-001 SHALL have parameter KERNEL_SIZE, default 5, the number of scratchpad lines.
REQ-002 SHALL have parameter DATA_BUS_WIDTH, default 128, the fetch beat width.
REQ-003 SHALL have parameter FEATURE_WIDTH, default 16, the feature width; FPB = DATA_BUS_WIDTH/FEATURE_WIDTH = 8 features per beat.
REQ-004 SHALL have parameter BEAT_W, default 8, the width of the beat counters.
REQ-005 SHALL have port clk, input, 1 bit, the clock.
REQ-006 SHALL have port rst, input, 1 bit, the reset; reset is asynchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit, a one-cycle pulse that launches a tile (honoured only in IDLE).
REQ-008 SHALL have port cfg_kn_mode, input, 1 bit, the kernel mode: 0 = 5x5, 1 = 3x3; sampled on start.
REQ-009 SHALL have port cfg_row_beats, input, BEAT_W bits, the number of beats per feature row (must be at least 1); sampled on start.
REQ-010 SHALL have port cfg_out_rows, input, BEAT_W bits, the number of output rows to stream (must be at least 1); sampled on start.
REQ-011 SHALL have ports fetch_valid (input, 1 bit), fetch_data (input, DATA_BUS_WIDTH bits) and fetch_ready (output, 1 bit), forming a valid/ready feature stream.
REQ-012 SHALL have port spad_wr_en, output, 1 bit, the scratchpad write enable.
REQ-013 SHALL have port spad_wr_mem_line, output, 4 bits, the scratchpad write line index.
REQ-014 SHALL have port spad_i_data, output, DATA_BUS_WIDTH bits, the scratchpad write data.
REQ-015 SHALL have port spad_rd_en, output, 1 bit, the scratchpad read enable for all lines.
REQ-016 SHALL have port spad_kn_size_mode, output, 1 bit, the latched kernel mode.
REQ-017 SHALL have ports spad_group_empty and spad_group_full, inputs, 1 bit each, the scratchpad status.
REQ-018 SHALL have port busy, output, 1 bit, high while not IDLE.
REQ-019 SHALL have port done, output, 1 bit, a one-cycle pulse at tile end.

Function
REQ-020 SHALL implement FSM states IDLE, PRELOAD, READ, DRAIN, DONE.
REQ-021 SHALL, in IDLE, on start latch cfg_* and go to PRELOAD; start outside IDLE is ignored.
REQ-022 SHALL set the first line FL = 0 in 5x5 mode and FL = 2 in 3x3 mode.
REQ-023 SHALL, in PRELOAD, write lines FL..KERNEL_SIZE-1 in order, cfg_row_beats beats each.
REQ-024 SHALL define a beat as accepted when fetch_valid and fetch_ready are both high.
REQ-025 SHALL pass spad_wr_en = accepted beat, spad_i_data = fetch_data and spad_wr_mem_line = current line combinationally, with zero latency.
REQ-026 SHALL deassert fetch_ready when spad_group_full is high.
REQ-027 SHALL go to READ after the last beat of line KERNEL_SIZE-1.
REQ-028 SHALL, in READ, assert spad_rd_en for exactly cfg_row_beats*FPB cycles, counted only on cycles where rd_en is high.
REQ-029 SHALL hold spad_rd_en low on any cycle where spad_group_empty is high; the count pauses and resumes without loss.
REQ-030 SHALL, in READ when rows remain after the current row, concurrently accept cfg_row_beats beats into line KERNEL_SIZE-1 only.
REQ-031 SHALL hold fetch_ready low in READ once the refill count completes, or when the current row is the last row.
REQ-032 SHALL go to DRAIN when both the read count and the refill count (if any) complete.
REQ-033 SHALL hold DRAIN for exactly 3 cycles, with rd_en and fetch_ready low, to let the line-shift writebacks land.
REQ-034 SHALL, at the end of DRAIN, increment the row counter, then go to READ if rows < cfg_out_rows, else go to DONE.
REQ-035 SHALL, in DONE, pulse done for 1 cycle and return to IDLE.
REQ-036 SHALL use counters that do not wrap; a beat counter at its terminal value advances the state in the same cycle as the last beat.

Reset
REQ-037 SHALL drive, under reset, state = IDLE, all counters = 0, spad_wr_en = 0, spad_rd_en = 0, fetch_ready = 0, busy = 0, done = 0, spad_wr_mem_line = 0, spad_kn_size_mode = 0 and latched cfg = 0.
REQ-038 SHALL, on rst asserted mid-tile, abort the tile immediately, emit no done pulse and leave scratchpad contents undefined.

Structure
REQ-039 SHALL define the FSM state enum, DRAIN_CYCLES = 3 and the mode encodings KN_MODE_5 = 0 and KN_MODE_3 = 1 in the shared network parameter package.
REQ-040 SHALL factor the beat/feature counting into one sub-module, spad_beat_counter (load, enable, terminal flag), instantiated once for write beats and once for read cycles.

Verification
REQ-041 SHALL cover: 5x5, row_beats = 2, out_rows = 1 -> 10 writes to lines 0,0,1,1,...,4,4; then 16 rd_en cycles; 3 drain cycles; done at the expected cycle.
REQ-042 SHALL cover: 3x3, row_beats = 1, out_rows = 2 -> writes to lines 2,3,4; 8 reads concurrent with 1 refill write to line 4; 8 more reads; done; spad_kn_size_mode = 1 throughout.
REQ-043 SHALL cover: fetch_valid toggling 50% in PRELOAD -> spad_wr_en matches accepted beats exactly, with no duplicated or skipped line index.
REQ-044 SHALL cover: spad_group_empty forced high for 4 cycles mid-READ -> rd_en low for those 4 cycles; total rd_en count remains 16.
REQ-045 SHALL cover: rst pulsed during READ -> all outputs go to reset values asynchronously; a subsequent start runs a clean tile.
REQ-046 SHALL cover: start pulsed while busy -> ignored, with cfg unchanged.
